// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the MEM stage and its SRAM controller.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      DONE
   } sram_state_t;

   localparam int DATA_MEM_BASE = 1024;
   localparam int REG_ADDR_W    = 5;

endpackage

// File: rtl/mem_stage_sram_if.sv
// Request/response channel between the MEM stage wrapper and the SRAM controller.
interface mem_stage_sram_if;

   logic        req;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (output req, wr, addr, wdata, input rdata, ready);
   modport slave  (input req, wr, addr, wdata, output rdata, ready);

endinterface

// File: rtl/sram_ctrl.sv
// Splits a 32-bit load/store into two half-word accesses on a 16-bit async SRAM.
module sram_ctrl
   import mips_pkg::*;
#(
   parameter int ADDR_OFFSET = DATA_MEM_BASE,
   parameter int WAIT_CYCLES = 1,
   parameter int SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   mem_stage_sram_if.slave    bus,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   localparam int CW = $clog2(WAIT_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

   sram_state_t        state;
   sram_state_t        next_state;
   logic [CW-1:0]      cnt;
   logic               op_wr;
   logic [SRAM_AW-2:0] waddr;
   logic [31:0]        st;
   logic [31:0]        rd;
   logic               phase_end;
   logic [31:0]        offset_addr;

   assign phase_end   = (cnt == LAST);
   assign offset_addr = bus.addr - 32'(ADDR_OFFSET);
   assign bus.rdata   = rd;
   assign bus.ready   = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.req) next_state = LO;
         LO:      if (phase_end) next_state = HI;
         HI:      if (phase_end) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Fields are captured only on leaving IDLE so upstream changes mid-access are ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         op_wr <= 1'b0;
         waddr <= '0;
         st    <= '0;
         rd    <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (bus.req) begin
                  op_wr <= bus.wr;
                  waddr <= offset_addr[SRAM_AW:2];
                  st    <= bus.wdata;
               end
            end
            LO, HI: begin
               cnt <= phase_end ? '0 : cnt + 1'b1;
               if (!op_wr && phase_end) begin
                  if (state == LO) rd[15:0]  <= sram_dq_in;
                  else             rd[31:16] <= sram_dq_in;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   always_comb begin
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      sram_oe_n   = 1'b1;
      if (state == LO || state == HI) begin
         sram_addr = {waddr, (state == HI)};
         if (op_wr) begin
            sram_dq_out = (state == HI) ? st[31:16] : st[15:0];
            sram_dq_oe  = 1'b1;
            sram_we_n   = 1'b0;
         end else begin
            sram_oe_n = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage: EXE/MEM pass-throughs plus SRAM load/store with a stall signal.
module mem_stage_sram
   import mips_pkg::*;
#(
   parameter int ADDR_OFFSET = DATA_MEM_BASE,
   parameter int WAIT_CYCLES = 1,
   parameter int SRAM_AW     = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  WB_en_in,
   input  logic                  MEM_R_EN_in,
   input  logic                  MEM_W_EN_in,
   input  logic [31:0]           ALU_result_in,
   input  logic [31:0]           ST_val_in,
   input  logic [REG_ADDR_W-1:0] Dest_in,
   output logic                  WB_en,
   output logic                  MEM_R_EN,
   output logic [31:0]           ALU_result,
   output logic [REG_ADDR_W-1:0] Dest,
   output logic [31:0]           MEM_read_value,
   output logic                  ready,
   output logic [SRAM_AW-1:0]    SRAM_ADDR,
   output logic [15:0]           SRAM_DQ_out,
   output logic                  SRAM_DQ_oe,
   input  logic [15:0]           SRAM_DQ_in,
   output logic                  SRAM_WE_N,
   output logic                  SRAM_OE_N
);

   mem_stage_sram_if bus ();

   assign WB_en      = WB_en_in;
   assign MEM_R_EN   = MEM_R_EN_in;
   assign ALU_result = ALU_result_in;
   assign Dest       = Dest_in;

   // A store wins when both enables are set
   assign bus.req   = MEM_R_EN_in | MEM_W_EN_in;
   assign bus.wr    = MEM_W_EN_in;
   assign bus.addr  = ALU_result_in;
   assign bus.wdata = ST_val_in;

   assign MEM_read_value = bus.rdata;
   assign ready          = ~bus.req | bus.ready;

   sram_ctrl #(
      .ADDR_OFFSET (ADDR_OFFSET),
      .WAIT_CYCLES (WAIT_CYCLES),
      .SRAM_AW     (SRAM_AW)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .sram_addr   (SRAM_ADDR),
      .sram_dq_out (SRAM_DQ_out),
      .sram_dq_oe  (SRAM_DQ_oe),
      .sram_dq_in  (SRAM_DQ_in),
      .sram_we_n   (SRAM_WE_N),
      .sram_oe_n   (SRAM_OE_N)
   );

endmodule
